// File: rtl/rd_forward_source_pipeline.sv
// rtl/rd_forward_source_pipeline.sv - destination-register pipeline EXECUTION->WB with load-use stall detection
module rd_forward_source_pipeline #(
   parameter int DATA_WIDTH    = 32,
   parameter int REG_ADD_WIDTH = 5
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     PIPELINE_FREEZE,
   input  logic [REG_ADD_WIDTH-1:0] RD_ADDRESS_EXECUTION,
   input  logic                     RD_WRITE_ENABLE_EXECUTION,
   input  logic [DATA_WIDTH-1:0]    RD_DATA_EXECUTION,
   input  logic                     IS_LOAD_EXECUTION,
   input  logic [DATA_WIDTH-1:0]    LOAD_DATA_DM3,
   input  logic [REG_ADD_WIDTH-1:0] RS1_ADDRESS_EXECUTION,
   input  logic                     RS1_READ_EXECUTION,
   input  logic [REG_ADD_WIDTH-1:0] RS2_ADDRESS_EXECUTION,
   input  logic                     RS2_READ_EXECUTION,
   output logic [REG_ADD_WIDTH-1:0] RD_ADDRESS_DM1,
   output logic                     RD_WRITE_ENABLE_DM1,
   output logic [DATA_WIDTH-1:0]    RD_DATA_DM1,
   output logic [REG_ADD_WIDTH-1:0] RD_ADDRESS_DM2,
   output logic                     RD_WRITE_ENABLE_DM2,
   output logic [DATA_WIDTH-1:0]    RD_DATA_DM2,
   output logic [REG_ADD_WIDTH-1:0] RD_ADDRESS_DM3,
   output logic                     RD_WRITE_ENABLE_DM3,
   output logic [DATA_WIDTH-1:0]    RD_DATA_DM3,
   output logic [REG_ADD_WIDTH-1:0] RD_ADDRESS_WB,
   output logic                     RD_WRITE_ENABLE_WB,
   output logic [DATA_WIDTH-1:0]    RD_DATA_WB,
   output logic                     STALL_EXECUTION_STAGE
);

   logic [REG_ADD_WIDTH-1:0] dm1_addr, dm2_addr, dm3_addr, wb_addr;
   logic                     dm1_we, dm2_we, dm3_we, wb_we;
   logic [DATA_WIDTH-1:0]    dm1_data, dm2_data, dm3_data, wb_data;
   logic                     dm1_ld, dm2_ld, dm3_ld;

   logic hit1_dm1, hit1_dm2, hit2_dm1, hit2_dm2;
   logic stall1, stall2, stall;
   logic ex_we;
   logic [DATA_WIDTH-1:0] dm3_result;

   // x0 is never a producer, so its enable is dropped on capture
   assign ex_we      = RD_WRITE_ENABLE_EXECUTION & (RD_ADDRESS_EXECUTION != '0);
   assign dm3_result = dm3_ld ? LOAD_DATA_DM3 : dm3_data;

   always_comb begin
      hit1_dm1 = RS1_READ_EXECUTION & (RS1_ADDRESS_EXECUTION != '0) &
                 (RS1_ADDRESS_EXECUTION == dm1_addr) & dm1_we;
      hit1_dm2 = RS1_READ_EXECUTION & (RS1_ADDRESS_EXECUTION != '0) &
                 (RS1_ADDRESS_EXECUTION == dm2_addr) & dm2_we;
      hit2_dm1 = RS2_READ_EXECUTION & (RS2_ADDRESS_EXECUTION != '0) &
                 (RS2_ADDRESS_EXECUTION == dm1_addr) & dm1_we;
      hit2_dm2 = RS2_READ_EXECUTION & (RS2_ADDRESS_EXECUTION != '0) &
                 (RS2_ADDRESS_EXECUTION == dm2_addr) & dm2_we;
      // A younger producer in DM1 shadows an older load in DM2
      stall1   = (hit1_dm1 & dm1_ld) | (hit1_dm2 & dm2_ld & ~hit1_dm1);
      stall2   = (hit2_dm1 & dm1_ld) | (hit2_dm2 & dm2_ld & ~hit2_dm1);
      stall    = stall1 | stall2;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         dm1_addr <= '0; dm1_we <= 1'b0; dm1_data <= '0; dm1_ld <= 1'b0;
         dm2_addr <= '0; dm2_we <= 1'b0; dm2_data <= '0; dm2_ld <= 1'b0;
         dm3_addr <= '0; dm3_we <= 1'b0; dm3_data <= '0; dm3_ld <= 1'b0;
         wb_addr  <= '0; wb_we  <= 1'b0; wb_data  <= '0;
      end else if (!PIPELINE_FREEZE) begin
         if (stall) begin
            dm1_addr <= '0;
            dm1_we   <= 1'b0;
            dm1_data <= '0;
            dm1_ld   <= 1'b0;
         end else begin
            dm1_addr <= RD_ADDRESS_EXECUTION;
            dm1_we   <= ex_we;
            dm1_data <= RD_DATA_EXECUTION;
            dm1_ld   <= IS_LOAD_EXECUTION;
         end
         dm2_addr <= dm1_addr; dm2_we <= dm1_we; dm2_data <= dm1_data; dm2_ld <= dm1_ld;
         dm3_addr <= dm2_addr; dm3_we <= dm2_we; dm3_data <= dm2_data; dm3_ld <= dm2_ld;
         wb_addr  <= dm3_addr;
         wb_we    <= dm3_we;
         wb_data  <= dm3_result;
      end
   end

   assign RD_ADDRESS_DM1        = dm1_addr;
   assign RD_WRITE_ENABLE_DM1   = dm1_we & ~dm1_ld;
   assign RD_DATA_DM1           = dm1_data;
   assign RD_ADDRESS_DM2        = dm2_addr;
   assign RD_WRITE_ENABLE_DM2   = dm2_we & ~dm2_ld;
   assign RD_DATA_DM2           = dm2_data;
   assign RD_ADDRESS_DM3        = dm3_addr;
   assign RD_WRITE_ENABLE_DM3   = dm3_we;
   assign RD_DATA_DM3           = dm3_result;
   assign RD_ADDRESS_WB         = wb_addr;
   assign RD_WRITE_ENABLE_WB    = wb_we;
   assign RD_DATA_WB            = wb_data;
   assign STALL_EXECUTION_STAGE = stall;

endmodule

// File: tb/tb_rd_forward_source_pipeline.sv
// tb/tb_rd_forward_source_pipeline.sv - directed-vector bench for rd_forward_source_pipeline
module tb_rd_forward_source_pipeline;

   logic        CLK = 1'b0;
   logic        RST;
   logic        PIPELINE_FREEZE;
   logic [4:0]  RD_ADDRESS_EXECUTION;
   logic        RD_WRITE_ENABLE_EXECUTION;
   logic [31:0] RD_DATA_EXECUTION;
   logic        IS_LOAD_EXECUTION;
   logic [31:0] LOAD_DATA_DM3;
   logic [4:0]  RS1_ADDRESS_EXECUTION;
   logic        RS1_READ_EXECUTION;
   logic [4:0]  RS2_ADDRESS_EXECUTION;
   logic        RS2_READ_EXECUTION;
   logic [4:0]  RD_ADDRESS_DM1, RD_ADDRESS_DM2, RD_ADDRESS_DM3, RD_ADDRESS_WB;
   logic        RD_WRITE_ENABLE_DM1, RD_WRITE_ENABLE_DM2, RD_WRITE_ENABLE_DM3, RD_WRITE_ENABLE_WB;
   logic [31:0] RD_DATA_DM1, RD_DATA_DM2, RD_DATA_DM3, RD_DATA_WB;
   logic        STALL_EXECUTION_STAGE;

   int n_vec = 0;
   int n_err = 0;

   // Stage snapshots as {addr, we, data}
   logic [37:0] s_dm1, s_dm2, s_dm3, s_wb;
   assign s_dm1 = {RD_ADDRESS_DM1, RD_WRITE_ENABLE_DM1, RD_DATA_DM1};
   assign s_dm2 = {RD_ADDRESS_DM2, RD_WRITE_ENABLE_DM2, RD_DATA_DM2};
   assign s_dm3 = {RD_ADDRESS_DM3, RD_WRITE_ENABLE_DM3, RD_DATA_DM3};
   assign s_wb  = {RD_ADDRESS_WB,  RD_WRITE_ENABLE_WB,  RD_DATA_WB};

   rd_forward_source_pipeline #(.DATA_WIDTH(32), .REG_ADD_WIDTH(5)) dut (
      .CLK(CLK), .RST(RST), .PIPELINE_FREEZE(PIPELINE_FREEZE),
      .RD_ADDRESS_EXECUTION(RD_ADDRESS_EXECUTION),
      .RD_WRITE_ENABLE_EXECUTION(RD_WRITE_ENABLE_EXECUTION),
      .RD_DATA_EXECUTION(RD_DATA_EXECUTION),
      .IS_LOAD_EXECUTION(IS_LOAD_EXECUTION),
      .LOAD_DATA_DM3(LOAD_DATA_DM3),
      .RS1_ADDRESS_EXECUTION(RS1_ADDRESS_EXECUTION),
      .RS1_READ_EXECUTION(RS1_READ_EXECUTION),
      .RS2_ADDRESS_EXECUTION(RS2_ADDRESS_EXECUTION),
      .RS2_READ_EXECUTION(RS2_READ_EXECUTION),
      .RD_ADDRESS_DM1(RD_ADDRESS_DM1), .RD_WRITE_ENABLE_DM1(RD_WRITE_ENABLE_DM1), .RD_DATA_DM1(RD_DATA_DM1),
      .RD_ADDRESS_DM2(RD_ADDRESS_DM2), .RD_WRITE_ENABLE_DM2(RD_WRITE_ENABLE_DM2), .RD_DATA_DM2(RD_DATA_DM2),
      .RD_ADDRESS_DM3(RD_ADDRESS_DM3), .RD_WRITE_ENABLE_DM3(RD_WRITE_ENABLE_DM3), .RD_DATA_DM3(RD_DATA_DM3),
      .RD_ADDRESS_WB(RD_ADDRESS_WB),   .RD_WRITE_ENABLE_WB(RD_WRITE_ENABLE_WB),   .RD_DATA_WB(RD_DATA_WB),
      .STALL_EXECUTION_STAGE(STALL_EXECUTION_STAGE)
   );

   always #5 CLK = ~CLK;

   // Advance one clock; inputs for the next cycle are applied 1 time unit after the edge
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_ex(input logic [4:0] rd, input logic we, input logic [31:0] data,
                         input logic ld, input logic [4:0] rs1, input logic r1,
                         input logic [4:0] rs2, input logic r2);
      RD_ADDRESS_EXECUTION      = rd;
      RD_WRITE_ENABLE_EXECUTION = we;
      RD_DATA_EXECUTION         = data;
      IS_LOAD_EXECUTION         = ld;
      RS1_ADDRESS_EXECUTION     = rs1;
      RS1_READ_EXECUTION        = r1;
      RS2_ADDRESS_EXECUTION     = rs2;
      RS2_READ_EXECUTION        = r2;
   endtask

   task automatic do_reset();
      set_ex(5'd0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      PIPELINE_FREEZE = 1'b0;
      LOAD_DATA_DM3   = 32'h0;
      RST = 1'b1;
      step();
      step();
      RST = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #2;
      n_vec++;
      if ({s_dm1, s_dm2, s_dm3, s_wb, STALL_EXECUTION_STAGE} !== 153'h0) begin
         n_err++;
         $display("FAIL reset_state got dm1=%h dm2=%h dm3=%h wb=%h stall=%b required all 0",
                  s_dm1, s_dm2, s_dm3, s_wb, STALL_EXECUTION_STAGE);
      end
   endtask

   task automatic test_alu_flow();
      do_reset();
      set_ex(5'd5, 1'b1, 32'hA1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      step();
      set_ex(5'd0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      #2;
      n_vec++;
      if (s_dm1 !== {5'd5, 1'b1, 32'hA1}) begin
         n_err++; $display("FAIL alu_dm1 got %h required %h", s_dm1, {5'd5, 1'b1, 32'hA1});
      end
      step(); #2;
      n_vec++;
      if (s_dm2 !== {5'd5, 1'b1, 32'hA1}) begin
         n_err++; $display("FAIL alu_dm2 got %h required %h", s_dm2, {5'd5, 1'b1, 32'hA1});
      end
      LOAD_DATA_DM3 = 32'h12345678;
      step(); #2;
      n_vec++;
      if (s_dm3 !== {5'd5, 1'b1, 32'hA1}) begin
         n_err++; $display("FAIL alu_dm3 got %h required %h", s_dm3, {5'd5, 1'b1, 32'hA1});
      end
      step(); #2;
      n_vec++;
      if (s_wb !== {5'd5, 1'b1, 32'hA1}) begin
         n_err++; $display("FAIL alu_wb got %h required %h", s_wb, {5'd5, 1'b1, 32'hA1});
      end
   endtask

   task automatic test_load_use();
      do_reset();
      set_ex(5'd6, 1'b1, 32'h100, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      step();
      set_ex(5'd9, 1'b1, 32'h55, 1'b0, 5'd6, 1'b1, 5'd0, 1'b0);
      #2;
      n_vec++;
      if ({STALL_EXECUTION_STAGE, s_dm1} !== {1'b1, 5'd6, 1'b0, 32'h100}) begin
         n_err++; $display("FAIL load_use_t1 got stall=%b dm1=%h required stall=1 dm1=%h",
                           STALL_EXECUTION_STAGE, s_dm1, {5'd6, 1'b0, 32'h100});
      end
      step(); #2;
      n_vec++;
      if ({STALL_EXECUTION_STAGE, s_dm1, s_dm2} !== {1'b1, 38'h0, 5'd6, 1'b0, 32'h100}) begin
         n_err++; $display("FAIL load_use_t2 got stall=%b dm1=%h dm2=%h required stall=1 dm1=0 dm2=%h",
                           STALL_EXECUTION_STAGE, s_dm1, s_dm2, {5'd6, 1'b0, 32'h100});
      end
      LOAD_DATA_DM3 = 32'hBEEF;
      step(); #2;
      n_vec++;
      if ({STALL_EXECUTION_STAGE, s_dm1, s_dm3} !== {1'b0, 38'h0, 5'd6, 1'b1, 32'hBEEF}) begin
         n_err++; $display("FAIL load_use_t3 got stall=%b dm1=%h dm3=%h required stall=0 dm1=0 dm3=%h",
                           STALL_EXECUTION_STAGE, s_dm1, s_dm3, {5'd6, 1'b1, 32'hBEEF});
      end
      step();
      set_ex(5'd0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      LOAD_DATA_DM3 = 32'h0;
      #2;
      n_vec++;
      if ({s_wb, s_dm1} !== {5'd6, 1'b1, 32'hBEEF, 5'd9, 1'b1, 32'h55}) begin
         n_err++; $display("FAIL load_use_t4 got wb=%h dm1=%h required wb=%h dm1=%h",
                           s_wb, s_dm1, {5'd6, 1'b1, 32'hBEEF}, {5'd9, 1'b1, 32'h55});
      end
   endtask

   task automatic test_shadow();
      do_reset();
      set_ex(5'd7, 1'b1, 32'h200, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      step();
      set_ex(5'd7, 1'b1, 32'h77, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      step();
      set_ex(5'd3, 1'b1, 32'h3, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
      #2;
      n_vec++;
      if ({STALL_EXECUTION_STAGE, RD_WRITE_ENABLE_DM1, RD_WRITE_ENABLE_DM2, RD_ADDRESS_DM2, RD_DATA_DM1}
          !== {1'b0, 1'b1, 1'b0, 5'd7, 32'h77}) begin
         n_err++; $display("FAIL shadow got stall=%b en1=%b en2=%b a2=%0d d1=%h required stall=0 en1=1 en2=0 a2=7 d1=77",
                           STALL_EXECUTION_STAGE, RD_WRITE_ENABLE_DM1, RD_WRITE_ENABLE_DM2,
                           RD_ADDRESS_DM2, RD_DATA_DM1);
      end
   endtask

   task automatic test_x0();
      do_reset();
      set_ex(5'd0, 1'b1, 32'h300, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      step();
      set_ex(5'd0, 1'b1, 32'h44, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1);
      for (int c = 0; c < 5; c++) begin
         #2;
         n_vec++;
         if ({STALL_EXECUTION_STAGE, RD_WRITE_ENABLE_DM1, RD_WRITE_ENABLE_DM2,
              RD_WRITE_ENABLE_DM3, RD_WRITE_ENABLE_WB} !== 5'b0) begin
            n_err++; $display("FAIL x0_cycle%0d got stall=%b en=%b%b%b%b required all 0", c,
                              STALL_EXECUTION_STAGE, RD_WRITE_ENABLE_DM1, RD_WRITE_ENABLE_DM2,
                              RD_WRITE_ENABLE_DM3, RD_WRITE_ENABLE_WB);
         end
         step();
      end
   endtask

   task automatic test_freeze();
      do_reset();
      set_ex(5'd8, 1'b1, 32'h400, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      step();
      set_ex(5'd10, 1'b1, 32'h1010, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0);
      PIPELINE_FREEZE = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #2;
         n_vec++;
         if ({STALL_EXECUTION_STAGE, s_dm1, s_dm2} !== {1'b1, 5'd8, 1'b0, 32'h400, 38'h0}) begin
            n_err++; $display("FAIL freeze_hold%0d got stall=%b dm1=%h dm2=%h required stall=1 dm1=%h dm2=0",
                              c, STALL_EXECUTION_STAGE, s_dm1, s_dm2, {5'd8, 1'b0, 32'h400});
         end
         step();
      end
      PIPELINE_FREEZE = 1'b0;
      #2;
      n_vec++;
      if ({STALL_EXECUTION_STAGE, RD_ADDRESS_DM1} !== {1'b1, 5'd8}) begin
         n_err++; $display("FAIL freeze_rel1 got stall=%b a1=%0d required stall=1 a1=8",
                           STALL_EXECUTION_STAGE, RD_ADDRESS_DM1);
      end
      step(); #2;
      n_vec++;
      if ({STALL_EXECUTION_STAGE, s_dm1, RD_ADDRESS_DM2} !== {1'b1, 38'h0, 5'd8}) begin
         n_err++; $display("FAIL freeze_rel2 got stall=%b dm1=%h a2=%0d required stall=1 dm1=0 a2=8",
                           STALL_EXECUTION_STAGE, s_dm1, RD_ADDRESS_DM2);
      end
      LOAD_DATA_DM3 = 32'hCAFE;
      step(); #2;
      n_vec++;
      if ({STALL_EXECUTION_STAGE, s_dm3} !== {1'b0, 5'd8, 1'b1, 32'hCAFE}) begin
         n_err++; $display("FAIL freeze_rel3 got stall=%b dm3=%h required stall=0 dm3=%h",
                           STALL_EXECUTION_STAGE, s_dm3, {5'd8, 1'b1, 32'hCAFE});
      end
   endtask

   task automatic test_reset_inflight();
      do_reset();
      for (int c = 0; c < 4; c++) begin
         set_ex(5'(11 + c), 1'b1, 32'h500 + c, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
         step();
      end
      set_ex(5'd20, 1'b1, 32'h20, 1'b0, 5'd14, 1'b1, 5'd0, 1'b0);
      LOAD_DATA_DM3 = 32'hDEAD;
      #2;
      n_vec++;
      if ({STALL_EXECUTION_STAGE, RD_ADDRESS_WB, RD_WRITE_ENABLE_WB} !== {1'b1, 5'd11, 1'b1}) begin
         n_err++; $display("FAIL inflight_pre got stall=%b awb=%0d enwb=%b required stall=1 awb=11 enwb=1",
                           STALL_EXECUTION_STAGE, RD_ADDRESS_WB, RD_WRITE_ENABLE_WB);
      end
      RST = 1'b1;
      PIPELINE_FREEZE = 1'b1;
      step();
      RST = 1'b0;
      PIPELINE_FREEZE = 1'b0;
      set_ex(5'd0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      #2;
      n_vec++;
      if ({s_dm1, s_dm2, s_dm3, s_wb, STALL_EXECUTION_STAGE} !== 153'h0) begin
         n_err++; $display("FAIL inflight_reset got dm1=%h dm2=%h dm3=%h wb=%h stall=%b required all 0",
                           s_dm1, s_dm2, s_dm3, s_wb, STALL_EXECUTION_STAGE);
      end
   endtask

   initial begin
      RST = 1'b1;
      #1;
      test_reset();
      test_alu_flow();
      test_load_use();
      test_shadow();
      test_x0();
      test_freeze();
      test_reset_inflight();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
